// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter.
//   - arb_state_e : port ownership state (idle / master 0 / master 1)
//   - default memory map: implemented depth and start of the MMIO window
//   - MMIO register addresses inside that window
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int NUM_MASTERS   = 2;
    localparam int MEM_DEPTH_DEF = 128;
    localparam int IO_BASE_DEF   = 121;

    // MMIO registers live at the top of the implemented range
    localparam int MMIO_REG0 = 121;
    localparam int MMIO_REG1 = 122;
    localparam int MMIO_REG2 = 125;
    localparam int MMIO_REG3 = 126;
    localparam int MMIO_REG4 = 127;

endpackage

// File: rtl/mem_port_guard.sv
// Combinational access guard for one master.
//   addr    : requested address
//   write   : 1 = write access
//   blocked : access must not reach memory (out of range, or a protected
//             write into the MMIO window)
module mem_port_guard
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int IO_BASE    = IO_BASE_DEF,
    parameter bit WRITE_PROT = 1'b0   // 1: writes at/above IO_BASE are refused
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    output logic              blocked
);

    logic out_of_range;
    logic io_write;

    assign out_of_range = (addr >= ADDR_W'(MEM_DEPTH));
    assign io_write     = WRITE_PROT & write & (addr >= ADDR_W'(IO_BASE));
    assign blocked      = out_of_range | io_write;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between master 0 (CPU
// datapath) and master 1 (UART loader / debug), with bounded burst lock
// and address protection.
//   clk, rst_n            : clock, async active-low reset
//   mX_req/lock/write/addr/wdata : master X request side
//   mX_gnt                : master X owns the port (decoded from state)
//   mX_rdata/rvalid/err   : registered read data, read pulse, blocked pulse
//   mem_addr/data_in/write: muxed port towards memory
//   mem_data_out          : combinational read data from memory
//   busy                  : port is owned by a master
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int IO_BASE   = IO_BASE_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  logic                 m0_lock,
    input  logic                 m0_write,
    input  logic [ADDR_W-1:0]    m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic [WORD_SIZE-1:0] m0_rdata,
    output logic                 m0_rvalid,
    output logic                 m0_err,
    input  logic                 m1_req,
    input  logic                 m1_lock,
    input  logic                 m1_write,
    input  logic [ADDR_W-1:0]    m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic [WORD_SIZE-1:0] m1_rdata,
    output logic                 m1_rvalid,
    output logic                 m1_err,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_data_out,
    output logic                 busy
);

    localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

    arb_state_e state, state_nxt;
    logic       last_owner;
    logic [BW-1:0] burst_cnt;

    logic [NUM_MASTERS-1:0]                 req, lock, wr, gnt, acc, blk;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0]     addr_v;
    logic [NUM_MASTERS-1:0][WORD_SIZE-1:0]  wdata_v, rdata_q;
    logic [NUM_MASTERS-1:0]                 rvalid_q, err_q;

    logic own;        // current owner index, meaningful only when busy
    logic lo_eff;     // last owner including an access happening this cycle
    logic at_limit;
    logic stay_lock;

    assign req     = {m1_req,   m0_req};
    assign lock    = {m1_lock,  m0_lock};
    assign wr      = {m1_write, m0_write};
    assign addr_v  = {m1_addr,  m0_addr};
    assign wdata_v = {m1_wdata, m0_wdata};

    // Only master 1 is refused writes into the MMIO window
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_guard
        mem_port_guard #(
            .ADDR_W    (ADDR_W),
            .MEM_DEPTH (MEM_DEPTH),
            .IO_BASE   (IO_BASE),
            .WRITE_PROT(g == 1)
        ) u_guard (
            .addr   (addr_v[g]),
            .write  (wr[g]),
            .blocked(blk[g])
        );
    end

    assign gnt  = {state == ST_OWN1, state == ST_OWN0};
    assign acc  = gnt & req;
    assign own  = (state == ST_OWN1);
    assign busy = (state != ST_IDLE);

    // A handover decided in an access cycle must see that access as the
    // most recent one, otherwise the same master could win twice in a row.
    assign lo_eff   = acc[0] ? 1'b0 : (acc[1] ? 1'b1 : last_owner);
    assign at_limit = (burst_cnt >= BW'(MAX_BURST - 1));

    always_comb begin
        state_nxt = ST_IDLE;
        stay_lock = 1'b0;
        if (busy && req[own] && lock[own] && (!at_limit || !req[!own]))
            stay_lock = 1'b1;
        if (stay_lock)
            state_nxt = state;
        else if (req[0] && req[1])
            state_nxt = lo_eff ? ST_OWN0 : ST_OWN1;
        else if (req[0])
            state_nxt = ST_OWN0;
        else if (req[1])
            state_nxt = ST_OWN1;
    end

    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_write   = 1'b0;
        if (busy) begin
            mem_addr    = addr_v[own];
            mem_data_in = wdata_v[own];
            mem_write   = acc[own] & wr[own] & ~blk[own];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            rvalid_q   <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            last_owner <= lo_eff;
            // Limit reached with the other master idle: keep owning but
            // start a fresh burst window.
            if (stay_lock)
                burst_cnt <= at_limit ? '0 : burst_cnt + BW'(1);
            else if (state_nxt != state)
                burst_cnt <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                rvalid_q[i] <= acc[i] & ~wr[i];
                err_q[i]    <= acc[i] & blk[i];
                if (acc[i] && !wr[i])
                    rdata_q[i] <= blk[i] ? '0 : mem_data_out;
            end
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  typedef struct { logic wr; logic lk; logic [15:0] addr; logic [15:0] wdata; int start; } cmd_t;
  typedef struct { logic rd; logic err; logic [15:0] data; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, mem_load = 1'b1;
  logic req_d [2], lock_d [2], wr_d [2];
  logic [15:0] addr_d [2], wdata_d [2];
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_write, busy;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_data_in, mem_data_out;

  logic [15:0] mem [128];
  logic [15:0] ref_mem [128];
  cmd_t q0[$], q1[$];
  exp_t e0[$], e1[$];
  int order_q[$], acc_cyc[$];
  bit act [2], pend [2];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_d[0]), .m0_lock(lock_d[0]), .m0_write(wr_d[0]), .m0_addr(addr_d[0]), .m0_wdata(wdata_d[0]),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(req_d[1]), .m1_lock(lock_d[1]), .m1_write(wr_d[1]), .m1_addr(addr_d[1]), .m1_wdata(wdata_d[1]),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 5) ? 16'h1234 : 16'h1000 + 16'(i);
  endfunction

  // memory stand-in: out-of-range reads return junk so blocked reads are visible
  always @(posedge clk) begin
    if (mem_load) for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    else if (mem_write && mem_addr < 16'd128) mem[mem_addr[6:0]] <= mem_data_in;
  end
  assign mem_data_out = (mem_addr < 16'd128) ? mem[mem_addr[6:0]] : 16'hDEAD;

  function automatic logic blk_ref(input int x, input logic w, input logic [15:0] a);
    return (a >= 16'd128) || (x == 1 && w && a >= 16'd121);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic start_cmd(input int x, input cmd_t c);
    exp_t e;
    logic b;
    b = blk_ref(x, c.wr, c.addr);
    req_d[x] = 1'b1; lock_d[x] = c.lk; wr_d[x] = c.wr; addr_d[x] = c.addr; wdata_d[x] = c.wdata;
    e.rd = !c.wr;
    e.err = b;
    e.data = (b || c.wr) ? 16'h0 : ref_mem[c.addr[6:0]];
    if (c.wr && !b) ref_mem[c.addr[6:0]] = c.wdata;
    if (x == 0) e0.push_back(e); else e1.push_back(e);
  endtask

  function automatic cmd_t mk(input logic w, input logic l, input int a, input int d, input int s);
    cmd_t c;
    c.wr = w; c.lk = l; c.addr = 16'(a); c.wdata = 16'(d); c.start = s;
    return c;
  endfunction

  // Drives both command queues (entered just after a rising edge), observes
  // access cycles at the falling edge and checks responses one cycle later.
  task automatic run(input string tag, input int max_cyc);
    int cyc = 0;
    bit done = 0;
    bit accd [2];
    logic g [2], rv [2], er [2];
    logic [15:0] rd [2];
    exp_t e;
    logic b;
    order_q.delete(); acc_cyc.delete();
    forever begin
      if (!act[0]) begin
        if (q0.size() > 0 && q0[0].start <= cyc) begin start_cmd(0, q0.pop_front()); act[0] = 1; end
        else begin req_d[0] = 0; lock_d[0] = 0; end
      end
      if (!act[1]) begin
        if (q1.size() > 0 && q1[0].start <= cyc) begin start_cmd(1, q1.pop_front()); act[1] = 1; end
        else begin req_d[1] = 0; lock_d[1] = 0; end
      end
      @(negedge clk);
      g[0] = m0_gnt; g[1] = m1_gnt; rv[0] = m0_rvalid; rv[1] = m1_rvalid;
      er[0] = m0_err; er[1] = m1_err; rd[0] = m0_rdata; rd[1] = m1_rdata;
      for (int x = 0; x < 2; x++) begin
        accd[x] = 0;
        if (pend[x]) begin
          if (x == 0) e = e0.pop_front(); else e = e1.pop_front();
          chk($sformatf("%s_rvalid%0d", tag, x), rv[x], e.rd);
          chk($sformatf("%s_err%0d", tag, x), er[x], e.err);
          if (e.rd) chk($sformatf("%s_rdata%0d", tag, x), rd[x], e.data);
          pend[x] = 0;
        end else if (rv[x] || er[x]) begin
          chk($sformatf("%s_stray%0d", tag, x), {rv[x], er[x]}, 2'b00);
        end
        if (g[x] && req_d[x]) begin
          b = blk_ref(x, wr_d[x], addr_d[x]);
          chk($sformatf("%s_maddr%0d", tag, x), mem_addr, addr_d[x]);
          chk($sformatf("%s_mwr%0d", tag, x), mem_write, wr_d[x] && !b);
          pend[x] = 1; accd[x] = 1;
          order_q.push_back(x); acc_cyc.push_back(cyc);
        end
      end
      @(posedge clk); #1; cyc++;
      for (int x = 0; x < 2; x++) if (accd[x]) act[x] = 0;
      if (q0.size() == 0 && q1.size() == 0 && !act[0] && !act[1] && !pend[0] && !pend[1]) begin
        done = 1; break;
      end
      if (cyc >= max_cyc) break;
    end
    req_d[0] = 0; req_d[1] = 0; lock_d[0] = 0; lock_d[1] = 0;
    chk({tag, "_done"}, done, 1'b1);
  endtask

  task automatic chk_order(input string tag, input int exp_ord[$]);
    chk({tag, "_len"}, order_q.size(), exp_ord.size());
    for (int i = 0; i < exp_ord.size() && i < order_q.size(); i++) begin
      chk($sformatf("%s_own%0d", tag, i), order_q[i], exp_ord[i]);
      chk($sformatf("%s_cyc%0d", tag, i), acc_cyc[i] - acc_cyc[0], i);
    end
  endtask

  initial begin
    int ord[$];
    for (int x = 0; x < 2; x++) begin
      req_d[x] = 0; lock_d[x] = 0; wr_d[x] = 0; addr_d[x] = 0; wdata_d[x] = 0;
    end
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1 mem_load = 0;
    @(negedge clk);
    chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {m1_rvalid, m0_rvalid, m1_err, m0_err}, 4'h0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 32'h0);
    chk("rst_mport", {mem_write, mem_addr}, 17'h0);
    rst_n = 1;
    @(posedge clk); #1;

    // single m0 read: gnt one cycle after req, data the cycle after
    req_d[0] = 1; wr_d[0] = 0; addr_d[0] = 16'd5;
    @(negedge clk); chk("rd_gnt_c1", m0_gnt, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_gnt_c2", m0_gnt, 1'b1);
    chk("rd_busy_c2", busy, 1'b1);
    chk("rd_addr_c2", mem_addr, 16'd5);
    @(posedge clk); #1 req_d[0] = 0;
    @(negedge clk);
    chk("rd_rvalid_c3", m0_rvalid, 1'b1);
    chk("rd_rdata_c3", m0_rdata, 16'h1234);
    chk("rd_err_c3", m0_err, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_rvalid_c4", m0_rvalid, 1'b0);
    chk("rd_hold_c4", m0_rdata, 16'h1234);
    @(posedge clk); #1;

    // reset during a granted write
    req_d[0] = 1; wr_d[0] = 1; addr_d[0] = 16'd10; wdata_d[0] = 16'hBEEF;
    @(posedge clk); #1;
    @(negedge clk); chk("rstw_pre", mem_write, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("rstw_mwr", mem_write, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_gnt", m0_gnt, 1'b0);
    req_d[0] = 0; wr_d[0] = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_pulse", {m0_rvalid, m0_err}, 2'b00);
    chk("rstw_rdata", m0_rdata, 16'h0);
    chk("rstw_mem", mem[10], 16'h100A);
    @(posedge clk); #1;

    // both request from idle, no lock: alternate without gaps
    q0.push_back(mk(0, 0, 1, 0, 0)); q0.push_back(mk(0, 0, 2, 0, 0));
    q1.push_back(mk(0, 0, 3, 0, 0)); q1.push_back(mk(0, 0, 4, 0, 0));
    run("rr", 40);
    ord = '{0, 1, 0, 1};
    chk_order("rr", ord);

    // m1 locked burst of 12 writes, m0 joins later
    for (int i = 0; i < 12; i++) q1.push_back(mk(1, 1, 20 + i, 16'hA000 + i, 0));
    q0.push_back(mk(0, 0, 40, 0, 2));
    run("burst", 60);
    ord = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    chk_order("burst", ord);
    q0.push_back(mk(0, 0, 20, 0, 0)); q0.push_back(mk(0, 0, 31, 0, 0));
    run("brd", 30);

    // MMIO protection for master 1 writes only
    q1.push_back(mk(1, 0, 127, 16'h1111, 0)); q1.push_back(mk(1, 0, 121, 16'h2222, 0));
    q1.push_back(mk(1, 0, 120, 16'h5555, 0)); q1.push_back(mk(0, 0, 127, 0, 0));
    run("mmio1", 30);
    q0.push_back(mk(1, 0, 127, 16'h7777, 0)); q0.push_back(mk(0, 0, 127, 0, 0));
    q0.push_back(mk(0, 0, 120, 0, 0));
    run("mmio0", 30);

    // out-of-range accesses
    q0.push_back(mk(0, 0, 200, 0, 0)); q0.push_back(mk(1, 0, 128, 16'h9999, 0));
    q0.push_back(mk(0, 0, 127, 0, 0));
    run("oor", 30);

    // locked burst alone keeps the port past the limit
    for (int i = 0; i < 10; i++) q0.push_back(mk(0, 1, 50 + i, 0, 0));
    run("solo", 40);
    ord = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_order("solo", ord);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
